yurut_birim_denetleyici: RTL and testbench

- Sequences the execute-stage functional units: single-cycle AMB/SISTEM results pass straight through; multi-cycle units (CARPMA, BOLME, SIFRELEME, YAPAYZEKA) receive a start pulse.
- Holds the front of the pipeline stalled until the selected unit finishes, then flags the result valid for the GERIYAZ-facing register.
- Also handles pipeline flush and watchdog timeout of a hung unit.

---
 rtl/yurut_birim_denetleyici.sv | 145 ++++++++++++++
 tb/tb_yurut_birim_denetleyici.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/yurut_birim_denetleyici.sv
// Execute-stage unit sequencer: passes single-cycle results through, starts multi-cycle
// units, stalls the front end until they finish, and handles flush and watchdog timeout.
module yurut_birim_denetleyici #(
  parameter int unsigned CARP_GECIKME = 3,
  parameter int unsigned ZAMAN_ASIMI  = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       gecerli_i,
  input  logic [2:0] birim_i,
  input  logic       bosalt_i,
  input  logic [3:0] birim_bitti_i,
  output logic [3:0] baslat_o,
  output logic       durdur_o,
  output logic       sonuc_gecerli_o,
  output logic [2:0] sonuc_birim_o,
  output logic       iptal_o,
  output logic       mesgul_o,
  output logic       zaman_asimi_o
);

  localparam int unsigned SW = $clog2(ZAMAN_ASIMI + 1);

  localparam logic [2:0] AMB       = 3'd0;
  localparam logic [2:0] CARPMA    = 3'd1;
  localparam logic [2:0] BOLME     = 3'd2;
  localparam logic [2:0] SIFRELEME = 3'd3;
  localparam logic [2:0] YAPAYZEKA = 3'd4;
  localparam logic [2:0] SISTEM    = 3'd5;

  typedef enum logic [1:0] {BOSTA, BEKLE, TAMAM, HATA} durum_t;

  durum_t        durum, sonraki;
  logic [SW-1:0] sayac, sayac_d;
  logic [2:0]    birim_q, birim_d;
  logic          tek_dongu, cok_dongu, bitti;
  logic          unused_bitti0;

  // CARPMA has no done strobe; its latency is counted instead.
  assign unused_bitti0 = birim_bitti_i[0];

  assign tek_dongu = (birim_i == AMB) || (birim_i == SISTEM);
  assign cok_dongu = (birim_i == CARPMA) || (birim_i == BOLME) ||
                     (birim_i == SIFRELEME) || (birim_i == YAPAYZEKA);

  always_comb begin
    bitti = 1'b0;
    unique case (birim_q)
      CARPMA:    bitti = (sayac == SW'(CARP_GECIKME - 1));
      BOLME:     bitti = birim_bitti_i[1];
      SIFRELEME: bitti = birim_bitti_i[2];
      YAPAYZEKA: bitti = birim_bitti_i[3];
      default:   bitti = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum   <= BOSTA;
      sayac   <= '0;
      birim_q <= AMB;
    end else begin
      durum   <= sonraki;
      sayac   <= sayac_d;
      birim_q <= birim_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    sonraki = durum;
    sayac_d = sayac;
    birim_d = birim_q;
    if (bosalt_i) begin
      sonraki = BOSTA;
      sayac_d = '0;
    end else begin
      unique case (durum)
        BOSTA: begin
          if (gecerli_i && cok_dongu) begin
            sonraki = BEKLE;
            birim_d = birim_i;
            sayac_d = '0;
          end
        end
        BEKLE: begin
          sayac_d = sayac + SW'(1);
          if (bitti)
            sonraki = TAMAM;
          else if (sayac == SW'(ZAMAN_ASIMI - 1))
            sonraki = HATA;
        end
        TAMAM:   sonraki = BOSTA;
        HATA:    sonraki = BOSTA;
        default: sonraki = BOSTA;
      endcase
    end
  end

  always_comb begin
    baslat_o        = '0;
    durdur_o        = 1'b0;
    sonuc_gecerli_o = 1'b0;
    sonuc_birim_o   = '0;
    iptal_o         = 1'b0;
    mesgul_o        = 1'b0;
    if (rst_ni) begin
      mesgul_o      = (durum != BOSTA);
      sonuc_birim_o = (durum == BOSTA) ? birim_i : birim_q;
      if (bosalt_i) begin
        iptal_o = (durum != BOSTA);
      end else begin
        unique case (durum)
          BOSTA: begin
            if (gecerli_i && tek_dongu) begin
              sonuc_gecerli_o = 1'b1;
            end else if (gecerli_i && cok_dongu) begin
              durdur_o = 1'b1;
              unique case (birim_i)
                CARPMA:    baslat_o = 4'b0001;
                BOLME:     baslat_o = 4'b0010;
                SIFRELEME: baslat_o = 4'b0100;
                default:   baslat_o = 4'b1000;
              endcase
            end
          end
          BEKLE:   durdur_o        = 1'b1;
          TAMAM:   sonuc_gecerli_o = 1'b1;
          HATA:    iptal_o         = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Sticky: once a unit has hung, software must see it until the next reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      zaman_asimi_o <= 1'b0;
    else if (durum == HATA)
      zaman_asimi_o <= 1'b1;
  end

endmodule

// File: tb/tb_yurut_birim_denetleyici.sv
// Bench for yurut_birim_denetleyici: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model of the unit sequencing rules.
module tb_yurut_birim_denetleyici;

  localparam int G = 3;
  localparam int Z = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       gecerli_i = 1'b0;
  logic [2:0] birim_i = '0;
  logic       bosalt_i = 1'b0;
  logic [3:0] birim_bitti_i = '0;
  logic [3:0] baslat_o;
  logic       durdur_o, sonuc_gecerli_o, iptal_o, mesgul_o, zaman_asimi_o;
  logic [2:0] sonuc_birim_o;

  yurut_birim_denetleyici #(.CARP_GECIKME(G), .ZAMAN_ASIMI(Z)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .gecerli_i(gecerli_i), .birim_i(birim_i),
    .bosalt_i(bosalt_i), .birim_bitti_i(birim_bitti_i), .baslat_o(baslat_o),
    .durdur_o(durdur_o), .sonuc_gecerli_o(sonuc_gecerli_o), .sonuc_birim_o(sonuc_birim_o),
    .iptal_o(iptal_o), .mesgul_o(mesgul_o), .zaman_asimi_o(zaman_asimi_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int passes = 0;

  // Model: which unit is in flight and how many wait cycles it has used.
  bit in_flight, result_now, hung, sticky;
  int unit, age;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    in_flight = 0; result_now = 0; hung = 0; sticky = 0; unit = 0; age = 0;
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic step(input bit g, input int b, input bit fl, input logic [3:0] bt);
    logic [3:0] e_bas;
    bit e_dur, e_sg, e_ipt, e_mes, done;
    int e_sb;
    @(negedge clk_i);
    gecerli_i = g; birim_i = 3'(b); bosalt_i = fl; birim_bitti_i = bt;
    #1;
    e_bas = 0; e_dur = 0; e_sg = 0; e_ipt = 0; e_sb = -1;
    e_mes = in_flight || result_now || hung;
    if (fl) e_ipt = e_mes;
    else if (hung) e_ipt = 1;
    else if (result_now) begin e_sg = 1; e_sb = unit; end
    else if (in_flight) begin e_dur = 1; e_sb = unit; end
    else if (g && (b == 0 || b == 5)) begin e_sg = 1; e_sb = b; end
    else if (g && b >= 1 && b <= 4) begin e_bas = 4'(1 << (b - 1)); e_dur = 1; end
    chk("baslat", baslat_o, e_bas);
    chk("durdur", {3'b0, durdur_o}, {3'b0, e_dur});
    chk("sonuc_gecerli", {3'b0, sonuc_gecerli_o}, {3'b0, e_sg});
    chk("iptal", {3'b0, iptal_o}, {3'b0, e_ipt});
    chk("mesgul", {3'b0, mesgul_o}, {3'b0, e_mes});
    chk("zaman_asimi", {3'b0, zaman_asimi_o}, {3'b0, sticky});
    if (e_sb >= 0) chk("sonuc_birim", {1'b0, sonuc_birim_o}, 4'(e_sb));
    if (hung) sticky = 1;
    if (fl) begin
      in_flight = 0; result_now = 0; hung = 0;
    end else if (hung) hung = 0;
    else if (result_now) result_now = 0;
    else if (in_flight) begin
      done = (unit == 1) ? (age == G - 1) : bt[unit - 1];
      if (done) begin in_flight = 0; result_now = 1; end
      else if (age == Z - 1) begin in_flight = 0; hung = 1; end
      else age++;
    end else if (g && b >= 1 && b <= 4) begin
      in_flight = 1; unit = b; age = 0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_baslat"}, baslat_o, 4'h0);
    chk({tag, "_ctl"}, {durdur_o, sonuc_gecerli_o, iptal_o, mesgul_o}, 4'h0);
    chk({tag, "_sonuc_birim"}, {1'b0, sonuc_birim_o}, 4'h0);
    chk({tag, "_zaman_asimi"}, {3'b0, zaman_asimi_o}, 4'h0);
  endtask

  initial begin
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // AMB then SISTEM back to back.
    step(1, 0, 0, 4'h0);
    step(1, 5, 0, 4'h0);

    // CARPMA: start then wait through the fixed latency and result.
    step(1, 1, 0, 4'h0);
    repeat (G + 2) step(0, 0, 0, 4'h0);

    // BOLME with a wrong-unit strobe at +2 and its own done at +5.
    step(1, 2, 0, 4'h0);
    step(0, 0, 0, 4'h0);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'h0);
    step(0, 0, 0, 4'h0);
    step(0, 0, 0, 4'b0010);
    step(0, 0, 0, 4'h0);
    step(0, 0, 0, 4'h0);

    // SIFRELEME flushed at +3.
    step(1, 3, 0, 4'h0);
    step(0, 0, 0, 4'h0);
    step(0, 0, 0, 4'h0);
    step(0, 0, 1, 4'h0);
    step(0, 0, 0, 4'h0);

    // YAPAYZEKA that never finishes: watchdog fires, error stays sticky.
    step(1, 4, 0, 4'h0);
    repeat (Z + 2) step(0, 0, 0, 4'h0);
    step(1, 0, 0, 4'h0);
    step(1, 1, 0, 4'h0);
    repeat (G + 1) step(0, 0, 0, 4'h0);

    // Back-to-back multi-cycle: a new start right after the result cycle.
    step(1, 2, 0, 4'h0);
    step(1, 2, 0, 4'b0010);
    step(1, 2, 0, 4'h0);
    step(1, 3, 0, 4'h0);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'h0);
    step(0, 0, 0, 4'h0);

    // Reserved codes are no-ops; bitti in idle is ignored.
    step(1, 6, 0, 4'hF);
    step(1, 7, 0, 4'hF);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
           $urandom_range(0, 15) == 0,
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
    end

    // Asynchronous reset mid-wait with the done strobe raised at the same time.
    repeat (2) step(0, 0, 0, 4'h0);
    step(1, 3, 0, 4'h0);
    step(0, 0, 0, 4'h0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    birim_bitti_i = 4'b0100;
    gecerli_i = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    birim_bitti_i = 4'h0;
    model_reset();
    step(0, 0, 0, 4'h0);
    step(0, 0, 0, 4'h0);
    step(1, 0, 0, 4'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
